param_register_file_sb: RTL

- Parametrised successor to the processor's 8x16 register file: generic width and depth, two asynchronous read ports, one synchronous write port.
- Adds optional write-to-read bypass, an optional hardwired zero register, a per-register busy scoreboard for multi-cycle writeback hazards, and a sequential bulk-clear engine.
- Sits between decode (read and reserve) and writeback (write and release) in the multi-cycle datapath.

---
 rtl/param_register_file_sb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/param_register_file_sb.sv
// Parametrised register file with two async read ports, one sync write port,
// optional bypass/zero register, per-register busy scoreboard and bulk-clear engine.
module param_register_file_sb #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] input_reg_readA_address,
    input  logic [ADDR_WIDTH-1:0] input_reg_readB_address,
    output logic [DATA_WIDTH-1:0] output_reg_A,
    output logic [DATA_WIDTH-1:0] output_reg_B,
    output logic                  output_busy_A,
    output logic                  output_busy_B,
    input  logic                  input_reg_write,
    input  logic [ADDR_WIDTH-1:0] input_reg_write_address,
    input  logic [DATA_WIDTH-1:0] input_reg_write_value,
    input  logic                  input_reserve,
    input  logic [ADDR_WIDTH-1:0] input_reserve_address,
    input  logic                  input_clear_start,
    output logic                  output_clear_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
    logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]        busy_q, busy_d;

    logic                    wr_en;
    logic                    rsv_en;
    logic                    zero_a;
    logic                    zero_b;

    // Address 0 is inert when the hardwired zero register is enabled.
    always_comb begin
        wr_en  = input_reg_write && (state_q == ST_IDLE) &&
                 !((ZERO_REG != 0) && (input_reg_write_address == '0));
        rsv_en = input_reserve && (state_q == ST_IDLE) &&
                 !((ZERO_REG != 0) && (input_reserve_address == '0));
        zero_a = (ZERO_REG != 0) && (input_reg_readA_address == '0);
        zero_b = (ZERO_REG != 0) && (input_reg_readB_address == '0);
    end

    // Next-state: writes/reserves in IDLE, one register zeroed per cycle in CLEAR.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    regs_d[input_reg_write_address] = input_reg_write_value;
                    busy_d[input_reg_write_address] = 1'b0;
                end
                // Applied after the write so a same-cycle reservation wins.
                if (rsv_en) begin
                    busy_d[input_reserve_address] = 1'b1;
                end
                if (input_clear_start) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                regs_d[idx_q] = '0;
                busy_d[idx_q] = 1'b0;
                idx_d         = idx_q + ADDR_WIDTH'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            regs_q  <= regs_d;
        end
    end

    // Read ports; busy outputs reflect registered state only.
    always_comb begin
        output_reg_A  = regs_q[input_reg_readA_address];
        output_reg_B  = regs_q[input_reg_readB_address];
        output_busy_A = busy_q[input_reg_readA_address];
        output_busy_B = busy_q[input_reg_readB_address];
        if ((BYPASS != 0) && wr_en && (input_reg_write_address == input_reg_readA_address)) begin
            output_reg_A = input_reg_write_value;
        end
        if ((BYPASS != 0) && wr_en && (input_reg_write_address == input_reg_readB_address)) begin
            output_reg_B = input_reg_write_value;
        end
        if (zero_a) begin
            output_reg_A  = '0;
            output_busy_A = 1'b0;
        end
        if (zero_b) begin
            output_reg_B  = '0;
            output_busy_B = 1'b0;
        end
    end

    assign output_clear_busy = (state_q == ST_CLEAR);

endmodule
